// File: rtl/pipe_hazard_ctrl_if.sv
// Bus-side signal bundle for the pipeline hazard controller: instruction-bus
// and data-bus handshakes, plus the fetch/memory request qualifiers that
// drive them.
//
// Handshake: a request strobe (imem_req/dmem_req) is held high until the
// bus answers with *_addr_ok in the same cycle. The access then stays
// outstanding until *_data_ok, which comes no earlier than the cycle after
// addr_ok. data_ok is ignored when no access is outstanding.
interface pipe_hazard_ctrl_if;
  logic f_req;
  logic imem_addr_ok;
  logic imem_data_ok;
  logic imem_req;
  logic imem_discard;
  logic m_mem_req;
  logic dmem_addr_ok;
  logic dmem_data_ok;
  logic dmem_req;

  // Controller side
  modport master (
    input  f_req, imem_addr_ok, imem_data_ok,
    input  m_mem_req, dmem_addr_ok, dmem_data_ok,
    output imem_req, imem_discard, dmem_req
  );

  // Pipeline/bus side
  modport slave (
    output f_req, imem_addr_ok, imem_data_ok,
    output m_mem_req, dmem_addr_ok, dmem_data_ok,
    input  imem_req, imem_discard, dmem_req
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/bubble/flush controller for the 5-stage F/D/E/M/W pipeline.
// Tracks outstanding ibus/dbus transactions with two small FSMs, detects
// load-use hazards, applies redirect flushes, drops stale fetch responses
// after a redirect, and counts stall_f cycles in a saturating counter.
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  d_srcA,
  input  logic [REG_W-1:0]  d_srcB,
  input  logic              d_useA,
  input  logic              d_useB,
  input  logic [REG_W-1:0]  e_dstM,
  input  logic              e_is_load,
  input  logic              d_redirect,
  pipe_hazard_ctrl_if.master bus,
  output logic              stall_f,
  output logic              stall_d,
  output logic              bubble_d,
  output logic              flush_d,
  output logic              stall_e,
  output logic              bubble_e,
  output logic              stall_m,
  output logic              bubble_w,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_i_state,
  output logic [1:0]        dbg_d_state,
  output logic              dbg_discard
);

  typedef enum logic [1:0] {I_IDLE = 2'd0, I_ADDR = 2'd1, I_DATA = 2'd2} i_state_t;
  typedef enum logic [1:0] {D_IDLE = 2'd0, D_ADDR = 2'd1, D_DATA = 2'd2} d_state_t;

  i_state_t i_state_q, i_state_d;
  d_state_t d_state_q, d_state_d;
  logic     discard_q, discard_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_busy, fetch_busy, load_use, redirect_eff;
  logic imem_req_raw, dmem_req_raw, imem_discard_raw;
  logic sf_raw, sd_raw, bd_raw, fd_raw, se_raw, be_raw, sm_raw, bw_raw;

  // State registers: both bus FSMs, stale-fetch flag and stall counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_state_q <= I_IDLE;
      d_state_q <= D_IDLE;
      discard_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      i_state_q <= i_state_d;
      d_state_q <= d_state_d;
      discard_q <= discard_d;
      cnt_q     <= cnt_d;
    end
  end

  // Dbus FSM: next state and request strobe
  always_comb begin
    d_state_d    = d_state_q;
    dmem_req_raw = 1'b0;
    case (d_state_q)
      D_IDLE: begin
        dmem_req_raw = bus.m_mem_req;
        if (bus.m_mem_req) d_state_d = bus.dmem_addr_ok ? D_DATA : D_ADDR;
      end
      D_ADDR: begin
        dmem_req_raw = 1'b1;
        if (bus.dmem_addr_ok) d_state_d = D_DATA;
      end
      D_DATA: begin
        if (bus.dmem_data_ok) d_state_d = D_IDLE;
      end
      default: d_state_d = D_IDLE;
    endcase
  end

  // Ibus FSM: next state and request strobe
  always_comb begin
    i_state_d    = i_state_q;
    imem_req_raw = 1'b0;
    case (i_state_q)
      I_IDLE: begin
        imem_req_raw = bus.f_req;
        if (bus.f_req) i_state_d = bus.imem_addr_ok ? I_DATA : I_ADDR;
      end
      I_ADDR: begin
        imem_req_raw = 1'b1;
        if (bus.imem_addr_ok) i_state_d = I_DATA;
      end
      I_DATA: begin
        if (bus.imem_data_ok) i_state_d = I_IDLE;
      end
      default: i_state_d = I_IDLE;
    endcase
  end

  // Hazard detection and prioritised stage controls
  always_comb begin
    mem_busy   = (bus.m_mem_req || d_state_q != D_IDLE) &&
                 !(d_state_q == D_DATA && bus.dmem_data_ok);
    // A discarded response does not satisfy fetch; F must refetch.
    fetch_busy = (bus.f_req || i_state_q != I_IDLE) &&
                 !(i_state_q == I_DATA && bus.imem_data_ok && !discard_q);
    // Register 0 is hard-wired, so it never creates a hazard.
    load_use   = e_is_load && (e_dstM != '0) &&
                 ((d_useA && d_srcA == e_dstM) || (d_useB && d_srcB == e_dstM));
    redirect_eff = d_redirect && !mem_busy && !load_use;

    sf_raw = 1'b0; sd_raw = 1'b0; bd_raw = 1'b0; fd_raw = 1'b0;
    se_raw = 1'b0; be_raw = 1'b0; sm_raw = 1'b0; bw_raw = 1'b0;
    if (mem_busy) begin
      // Freeze F..M, drain W; a redirect waits until D is released.
      sf_raw = 1'b1; sd_raw = 1'b1; se_raw = 1'b1; sm_raw = 1'b1; bw_raw = 1'b1;
    end else if (load_use) begin
      sf_raw = 1'b1; sd_raw = 1'b1; be_raw = 1'b1;
    end else begin
      fd_raw = d_redirect;
      if (fetch_busy) begin
        sf_raw = 1'b1;
        bd_raw = !d_redirect;
      end
    end

    // Response is stale if a redirect was already pending or lands now.
    imem_discard_raw = (i_state_q == I_DATA) && bus.imem_data_ok &&
                       (discard_q || redirect_eff);
  end

  // Stale-fetch flag and saturating stall counter next-state
  always_comb begin
    discard_d = discard_q;
    if (i_state_q == I_DATA && bus.imem_data_ok)
      discard_d = 1'b0;
    else if (redirect_eff && (i_state_q == I_ADDR || i_state_q == I_DATA))
      discard_d = 1'b1;

    cnt_d = cnt_q;
    if (stall_f && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
  end

  // Outputs are forced low while reset is held
  always_comb begin
    bus.imem_req     = !reset && imem_req_raw;
    bus.dmem_req     = !reset && dmem_req_raw;
    bus.imem_discard = !reset && imem_discard_raw;
    stall_f  = !reset && sf_raw;
    stall_d  = !reset && sd_raw;
    bubble_d = !reset && bd_raw;
    flush_d  = !reset && fd_raw;
    stall_e  = !reset && se_raw;
    bubble_e = !reset && be_raw;
    stall_m  = !reset && sm_raw;
    bubble_w = !reset && bw_raw;
  end

  assign stall_cnt   = cnt_q;
  assign dbg_i_state = i_state_q;
  assign dbg_d_state = d_state_q;
  assign dbg_discard = discard_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl. A second instance with a 4-bit
// counter shares all stimulus to exercise counter saturation.
module tb_pipe_hazard_ctrl;
  localparam int REG_W = 5;

  // Bit positions of the packed control vector
  localparam logic [10:0] IREQ = 11'h400;
  localparam logic [10:0] DREQ = 11'h200;
  localparam logic [10:0] IDSC = 11'h100;
  localparam logic [10:0] SF   = 11'h080;
  localparam logic [10:0] SD   = 11'h040;
  localparam logic [10:0] BD   = 11'h020;
  localparam logic [10:0] FD   = 11'h010;
  localparam logic [10:0] SE   = 11'h008;
  localparam logic [10:0] BE   = 11'h004;
  localparam logic [10:0] SM   = 11'h002;
  localparam logic [10:0] BW   = 11'h001;
  localparam logic [10:0] MEMSTALL = SF | SD | SE | SM | BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [REG_W-1:0] d_srcA, d_srcB, e_dstM;
  logic d_useA, d_useB, e_is_load, d_redirect;
  logic stall_f, stall_d, bubble_d, flush_d, stall_e, bubble_e, stall_m, bubble_w;
  logic [31:0] stall_cnt;
  logic [1:0]  dbg_i_state, dbg_d_state;
  logic        dbg_discard;

  logic stall_f4, stall_d4, bubble_d4, flush_d4, stall_e4, bubble_e4, stall_m4, bubble_w4;
  logic [3:0]  stall_cnt4;
  logic [1:0]  dbg_i_state4, dbg_d_state4;
  logic        dbg_discard4;

  pipe_hazard_ctrl_if u_if ();
  pipe_hazard_ctrl_if u_if4 ();

  assign u_if4.f_req        = u_if.f_req;
  assign u_if4.imem_addr_ok = u_if.imem_addr_ok;
  assign u_if4.imem_data_ok = u_if.imem_data_ok;
  assign u_if4.m_mem_req    = u_if.m_mem_req;
  assign u_if4.dmem_addr_ok = u_if.dmem_addr_ok;
  assign u_if4.dmem_data_ok = u_if.dmem_data_ok;

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_useA(d_useA), .d_useB(d_useB),
    .e_dstM(e_dstM), .e_is_load(e_is_load), .d_redirect(d_redirect),
    .bus(u_if.master),
    .stall_f(stall_f), .stall_d(stall_d), .bubble_d(bubble_d), .flush_d(flush_d),
    .stall_e(stall_e), .bubble_e(bubble_e), .stall_m(stall_m), .bubble_w(bubble_w),
    .stall_cnt(stall_cnt),
    .dbg_i_state(dbg_i_state), .dbg_d_state(dbg_d_state), .dbg_discard(dbg_discard)
  );

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_useA(d_useA), .d_useB(d_useB),
    .e_dstM(e_dstM), .e_is_load(e_is_load), .d_redirect(d_redirect),
    .bus(u_if4.master),
    .stall_f(stall_f4), .stall_d(stall_d4), .bubble_d(bubble_d4), .flush_d(flush_d4),
    .stall_e(stall_e4), .bubble_e(bubble_e4), .stall_m(stall_m4), .bubble_w(bubble_w4),
    .stall_cnt(stall_cnt4),
    .dbg_i_state(dbg_i_state4), .dbg_d_state(dbg_d_state4), .dbg_discard(dbg_discard4)
  );

  wire [10:0] ctrl = {u_if.imem_req, u_if.dmem_req, u_if.imem_discard,
                      stall_f, stall_d, bubble_d, flush_d,
                      stall_e, bubble_e, stall_m, bubble_w};

  // ---------------- scoreboard counters ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    d_srcA = '0; d_srcB = '0; d_useA = 1'b0; d_useB = 1'b0;
    e_dstM = '0; e_is_load = 1'b0; d_redirect = 1'b0;
    u_if.f_req = 1'b0; u_if.imem_addr_ok = 1'b0; u_if.imem_data_ok = 1'b0;
    u_if.m_mem_req = 1'b0; u_if.dmem_addr_ok = 1'b0; u_if.dmem_data_ok = 1'b0;
  endtask

  task automatic load_use_b8();
    e_is_load = 1'b1; e_dstM = 5'd8; d_useB = 1'b1; d_srcB = 5'd8;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle_inputs();
    reset = 1'b1;
    u_if.m_mem_req = 1'b1;
    u_if.f_req = 1'b1;
    #1;
    chk("reset_ctrl", ctrl, 11'h000);
    chk("reset_cnt", stall_cnt, 0);
    chk("reset_dstate", dbg_d_state, 0);
    tick();
    chk("reset_held_ctrl", ctrl, 11'h000);
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("idle_ctrl", ctrl, 11'h000);
    tick();

    // Load-use
    load_use_b8(); #1;
    chk("lu_srcB", ctrl, SF | SD | BE);
    tick();
    e_dstM = 5'd0; d_srcB = 5'd0; #1;
    chk("lu_r0", ctrl, 11'h000);
    tick();
    e_dstM = 5'd8; d_srcB = 5'd8; d_useB = 1'b0; #1;
    chk("lu_unused", ctrl, 11'h000);
    tick();
    d_useA = 1'b1; d_srcA = 5'd8; #1;
    chk("lu_srcA", ctrl, SF | SD | BE);
    tick();
    idle_inputs(); #1;
    chk("lu_done", ctrl, 11'h000);
    chk("cnt_after_lu", stall_cnt, 2);
    tick();

    // Dbus wait: addr_ok at cycle 2, data_ok at cycle 5
    u_if.m_mem_req = 1'b1; #1;
    chk("dbus_c0", ctrl, DREQ | MEMSTALL);
    tick();
    u_if.dmem_data_ok = 1'b1; #1;
    chk("dbus_c1_early_dok", ctrl, DREQ | MEMSTALL);
    chk("dbus_c1_state", dbg_d_state, 1);
    tick();
    u_if.dmem_data_ok = 1'b0; u_if.dmem_addr_ok = 1'b1; #1;
    chk("dbus_c2", ctrl, DREQ | MEMSTALL);
    tick();
    u_if.dmem_addr_ok = 1'b0; #1;
    chk("dbus_c3", ctrl, MEMSTALL);
    chk("dbus_c3_state", dbg_d_state, 2);
    tick();
    #1;
    chk("dbus_c4", ctrl, MEMSTALL);
    tick();
    u_if.dmem_data_ok = 1'b1; #1;
    chk("dbus_c5", ctrl, 11'h000);
    tick();
    idle_inputs(); #1;
    chk("dbus_idle_state", dbg_d_state, 0);
    chk("cnt_after_dbus", stall_cnt, 7);
    tick();

    // Priority: mem_busy + load_use + redirect
    u_if.m_mem_req = 1'b1; u_if.dmem_addr_ok = 1'b1;
    load_use_b8(); d_redirect = 1'b1; #1;
    chk("prio_all", ctrl, DREQ | MEMSTALL);
    tick();
    u_if.m_mem_req = 1'b0; u_if.dmem_addr_ok = 1'b0; u_if.dmem_data_ok = 1'b1; #1;
    chk("prio_lu_over_redirect", ctrl, SF | SD | BE);
    tick();
    u_if.dmem_data_ok = 1'b0; e_is_load = 1'b0; #1;
    chk("prio_redirect", ctrl, FD);
    tick();
    idle_inputs(); #1;
    chk("prio_no_discard", dbg_discard, 0);
    tick();

    // Redirect vs fetch in flight
    u_if.f_req = 1'b1; u_if.imem_addr_ok = 1'b1; #1;
    chk("ifetch_addr", ctrl, IREQ | SF | BD);
    tick();
    u_if.imem_addr_ok = 1'b0; d_redirect = 1'b1; #1;
    chk("redir_c0", ctrl, SF | FD);
    tick();
    d_redirect = 1'b0; #1;
    chk("redir_c1", ctrl, SF | BD);
    chk("redir_discard_set", dbg_discard, 1);
    tick();
    #1;
    chk("redir_c2", ctrl, SF | BD);
    tick();
    u_if.imem_data_ok = 1'b1; #1;
    chk("redir_c3_discard", ctrl, IDSC | SF | BD);
    tick();
    u_if.imem_data_ok = 1'b0; #1;
    chk("redir_c4_refetch", ctrl, IREQ | SF | BD);
    chk("redir_discard_clr", dbg_discard, 0);
    tick();
    u_if.imem_addr_ok = 1'b1; #1;
    chk("refetch_addr", ctrl, IREQ | SF | BD);
    tick();
    u_if.imem_addr_ok = 1'b0; u_if.imem_data_ok = 1'b1; d_redirect = 1'b1; #1;
    chk("same_cycle_redir", ctrl, IDSC | FD);
    tick();
    idle_inputs(); #1;
    chk("same_cycle_after", ctrl, 11'h000);
    chk("same_cycle_istate", dbg_i_state, 0);
    chk("same_cycle_flag", dbg_discard, 0);
    chk("cnt_after_ibus", stall_cnt, 16);
    chk("cnt4_after_ibus", stall_cnt4, 15);
    tick();

    // Counter: clear by reset, then 10, then 15 + 3
    reset = 1'b1; #1;
    reset = 1'b0; #1;
    chk("cnt_cleared", stall_cnt, 0);
    load_use_b8();
    for (int i = 0; i < 10; i++) tick();
    idle_inputs(); #1;
    chk("cnt_10", stall_cnt, 10);
    chk("cnt4_10", stall_cnt4, 10);
    load_use_b8();
    for (int i = 0; i < 5; i++) tick();
    idle_inputs(); #1;
    chk("cnt4_15", stall_cnt4, 15);
    load_use_b8();
    for (int i = 0; i < 3; i++) tick();
    idle_inputs(); #1;
    chk("cnt4_sat", stall_cnt4, 15);
    chk("cnt_18", stall_cnt, 18);
    tick();

    // Async reset in D_ADDR
    u_if.m_mem_req = 1'b1; #1;
    tick();
    chk("daddr_state", dbg_d_state, 1);
    chk("daddr_ctrl", ctrl, DREQ | MEMSTALL);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_ctrl", ctrl, 11'h000);
    chk("async_rst_state", dbg_d_state, 0);
    chk("async_rst_cnt", stall_cnt, 0);
    tick();
    chk("rst_held_ctrl", ctrl, 11'h000);
    reset = 1'b0; #1;
    chk("post_rst_req", ctrl, DREQ | MEMSTALL);
    u_if.m_mem_req = 1'b0; #1;
    chk("post_rst_noreq", ctrl, 11'h000);
    tick();

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage core (F/D/E/M/W). Each cycle it produces stall, bubble and flush controls for every stage register. It handles:
- load-use hazards between the D and E stages;
- taken-branch redirects resolved in D;
- multi-cycle instruction-bus and data-bus handshakes.

It holds small FSMs that track outstanding bus transactions, and keeps a saturating stall-cycle performance counter.

Parameters:
REG_W, 5, register-id width
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
d_srcA  in  REG_W  source A of instruction in D
d_srcB  in  REG_W  source B of instruction in D
d_useA  in  1  D actually reads srcA
d_useB  in  1  D actually reads srcB
e_dstM  in  REG_W  load destination of instruction in E
e_is_load  in  1  E holds a load
d_redirect  in  1  D resolved a taken branch/jump this cycle
f_req  in  1  F wants to fetch (valid PC)
imem_addr_ok  in  1  ibus accepted address
imem_data_ok  in  1  ibus returned instruction
m_mem_req  in  1  M holds a load/store
dmem_addr_ok  in  1  dbus accepted address
dmem_data_ok  in  1  dbus completed access
imem_req  out  1  ibus request strobe
dmem_req  out  1  dbus request strobe
imem_discard  out  1  returning instruction is stale, drop it
stall_f  out  1  hold PC / F register
stall_d  out  1  hold D register
bubble_d  out  1  load NOP into D
flush_d  out  1  kill D register (redirect)
stall_e  out  1  hold E register
bubble_e  out  1  load NOP into E
stall_m  out  1  hold M register
bubble_w  out  1  load NOP into W
stall_cnt  out  CNT_W  cycles with stall_f asserted

Behaviour:
- Reset (async, immediate effect):
  - FSMs go to IDLE; discard flag = 0; stall_cnt = 0.
  - While reset is high, all control and strobe outputs are forced to 0.
- Dbus FSM states: D_IDLE, D_ADDR, D_DATA.
  - D_IDLE: m_mem_req & dmem_addr_ok -> D_DATA; m_mem_req & !dmem_addr_ok -> D_ADDR.
  - D_ADDR: dmem_addr_ok -> D_DATA.
  - D_DATA: dmem_data_ok -> D_IDLE.
  - dmem_req = (D_IDLE & m_mem_req) | D_ADDR.
  - Protocol: dmem_data_ok arrives at earliest one cycle after addr_ok; data_ok outside D_DATA is ignored.
- Ibus FSM states: I_IDLE, I_ADDR, I_DATA, with the same transitions driven by f_req / imem_addr_ok / imem_data_ok.
  - imem_req = (I_IDLE & f_req) | I_ADDR.
- mem_busy = (m_mem_req | state != D_IDLE) & !(D_DATA & dmem_data_ok).
- fetch_busy = (f_req | state != I_IDLE) & !(I_DATA & imem_data_ok & !discard).
- load_use = e_is_load & e_dstM != 0 & ((d_useA & d_srcA == e_dstM) | (d_useB & d_srcB == e_dstM)). Register 0 never hazards.
- Priority, combinational, same cycle as the inputs:
  1. mem_busy: stall_f, stall_d, stall_e, stall_m = 1; bubble_w = 1. flush_d and bubble_e are suppressed; redirect re-evaluates when D is released.
  2. else load_use: stall_f = stall_d = 1, bubble_e = 1. flush_d is suppressed because D is stalled.
  3. else:
     - flush_d = d_redirect;
     - if fetch_busy: stall_f = 1 and bubble_d = 1, unless flush_d, in which case flush_d wins and bubble_d = 0.
- Discard flag:
  - Set on d_redirect & !mem_busy & !load_use while ibus is in I_ADDR or I_DATA (stale fetch in flight).
  - When I_DATA & imem_data_ok with discard = 1: imem_discard = 1 that cycle, discard clears, FSM -> I_IDLE, fetch_busy stays 1 (refetch from the new PC).
  - Redirect in the same cycle as a non-discarded data_ok: that response is also discarded; imem_discard = 1 in that cycle.
- stall_cnt: increments on every cycle with stall_f = 1; saturates at all-ones.
- Reset mid-transaction: FSMs abandon state immediately; no strobes until reset deasserts.

Test Plan:
1. Load-use: e_is_load = 1, e_dstM = 8, d_useB = 1, d_srcB = 8 -> stall_f = stall_d = bubble_e = 1 for exactly that cycle; with e_dstM = 0 -> no stall.
2. Dbus wait: m_mem_req = 1, addr_ok at cycle 2, data_ok at cycle 5 -> stall_m = stall_e = stall_d = stall_f = bubble_w = 1 in cycles 0-4; all 0 in cycle 5 (assuming no other hazard); dmem_req high in cycles 0-2 only.
3. Redirect vs fetch in flight: ibus in I_DATA, d_redirect = 1 at cycle 0, data_ok at cycle 3 -> flush_d = 1 at cycle 0; imem_discard = 1 at cycle 3; imem_req is reissued for the new PC at cycle 4 (FSM back in I_IDLE; request only if f_req = 1).
4. Priority: mem_busy, load_use and d_redirect all asserted together -> only the mem stall set is active; flush_d = 0, bubble_e = 0.
5. Counter: 10 stall cycles -> stall_cnt = 10; preload near max (CNT_W = 4, 15 stalls then 3 more) -> holds at 15.
6. Async reset asserted in D_ADDR mid-cycle -> all outputs 0 immediately; after release dmem_req follows m_mem_req from D_IDLE.
